neighbour_rule_pipe: RTL and testbench

NEIGHBOUR_RULE_PIPE -- requirements
Module: neighbour_rule_pipe

---
 rtl/neighbour_rule_pipe.sv | 148 ++++++++++++++
 tb/tb_neighbour_rule_pipe.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/neighbour_rule_pipe.sv
// neighbour_rule_pipe
//   Two-stage, valid/ready pipelined cellular-automaton rule evaluator.
//   S1 registers the live-neighbour count and the centre bit of an incoming
//   3x3 window. S2 registers the next-generation state and the count. A
//   saturating counter tallies delivered results whose cell is alive.
//
// Ports
//   clk         : sole clock, rising-edge
//   rst_n       : synchronous, active-low reset
//   in_valid    : in_window holds a neighbourhood
//   in_ready    : block accepts in_window this cycle
//   in_window   : 3x3 neighbourhood, row-major, bit 4 = centre cell
//   out_valid   : out_alive/out_count hold a result
//   out_ready   : downstream accepts the result this cycle
//   out_alive   : next-generation state of the centre cell
//   out_count   : live-neighbour count, 0..8
//   stats_clr   : synchronous clear of alive_total (wins over increment)
//   alive_total : saturating count of delivered results with out_alive=1

module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);
endmodule

module neighbour_rule_pipe #(
  parameter logic [8:0] BIRTH_MASK   = 9'b0_0000_1000,
  parameter logic [8:0] SURVIVE_MASK = 9'b0_0000_1100,
  parameter int         CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [8:0]       in_window,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_alive,
  output logic [3:0]       out_count,
  input  logic             stats_clr,
  output logic [CNT_W-1:0] alive_total
);

  // ---------------------------------------------------------------------
  // Neighbour count: carry-save tree of full adders over the 8 neighbours
  // ---------------------------------------------------------------------
  logic [7:0] nb;
  assign nb = {in_window[8:5], in_window[3:0]};

  // First level compresses neighbours 0..5 into two weight-1 sums and two
  // weight-2 carries.
  logic [1:0] l1_sum;
  logic [1:0] l1_carry;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_l1
      full_adder u_fa (
        .a    (nb[3*gi]),
        .b    (nb[3*gi+1]),
        .cin  (nb[3*gi+2]),
        .sum  (l1_sum[gi]),
        .cout (l1_carry[gi])
      );
    end
  endgenerate

  logic c_sum, c_carry, d_sum, d_carry;
  logic e_sum, e_carry, f_sum, f_carry;
  logic g_sum, g_carry;

  // Weight 1: remaining sums plus neighbours 6 and 7 -> count bit 0.
  full_adder u_fa_c (.a(l1_sum[0]), .b(l1_sum[1]), .cin(nb[6]), .sum(c_sum), .cout(c_carry));
  full_adder u_fa_d (.a(c_sum), .b(nb[7]), .cin(1'b0), .sum(d_sum), .cout(d_carry));
  // Weight 2: four carries -> count bit 1.
  full_adder u_fa_e (.a(l1_carry[0]), .b(l1_carry[1]), .cin(c_carry), .sum(e_sum), .cout(e_carry));
  full_adder u_fa_f (.a(e_sum), .b(d_carry), .cin(1'b0), .sum(f_sum), .cout(f_carry));
  // Weight 4: two carries -> count bits 2 and 3 (8 neighbours = 4'b1000).
  full_adder u_fa_g (.a(e_carry), .b(f_carry), .cin(1'b0), .sum(g_sum), .cout(g_carry));

  logic [3:0] count;
  assign count = {g_carry, g_sum, f_sum, d_sum};

  // ---------------------------------------------------------------------
  // Pipeline state and handshake
  // ---------------------------------------------------------------------
  logic             s1_valid_reg;
  logic [3:0]       s1_count_reg;
  logic             s1_centre_reg;
  logic             s2_valid_reg;
  logic             s2_alive_reg;
  logic [3:0]       s2_count_reg;
  logic [CNT_W-1:0] alive_total_reg;

  logic s1_ready, s2_ready, out_fire, next_alive;

  assign s2_ready = !s2_valid_reg || out_ready;
  assign s1_ready = !s1_valid_reg || s2_ready;
  // Equivalent to !s1_valid || !s2_valid || out_ready, held low in reset.
  assign in_ready = rst_n && s1_ready;
  assign out_fire = s2_valid_reg && out_ready;

  assign next_alive = s1_centre_reg ? SURVIVE_MASK[s1_count_reg]
                                    : BIRTH_MASK[s1_count_reg];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_reg    <= 1'b0;
      s1_count_reg    <= 4'd0;
      s1_centre_reg   <= 1'b0;
      s2_valid_reg    <= 1'b0;
      s2_alive_reg    <= 1'b0;
      s2_count_reg    <= 4'd0;
      alive_total_reg <= '0;
    end else begin
      if (s1_ready) begin
        s1_valid_reg <= in_valid;
        if (in_valid) begin
          s1_count_reg  <= count;
          s1_centre_reg <= in_window[4];
        end
      end
      // Result registers are zeroed when S2 empties so the outputs read 0
      // whenever out_valid is low.
      if (s2_ready) begin
        s2_valid_reg <= s1_valid_reg;
        s2_alive_reg <= s1_valid_reg && next_alive;
        s2_count_reg <= s1_valid_reg ? s1_count_reg : 4'd0;
      end
      if (stats_clr) begin
        alive_total_reg <= '0;
      end else if (out_fire && s2_alive_reg && (alive_total_reg != {CNT_W{1'b1}})) begin
        alive_total_reg <= alive_total_reg + 1'b1;
      end
    end
  end

  assign out_valid   = s2_valid_reg;
  assign out_alive   = s2_alive_reg;
  assign out_count   = s2_count_reg;
  assign alive_total = alive_total_reg;

endmodule

// File: tb/tb_neighbour_rule_pipe.sv
// tb_neighbour_rule_pipe
//   Drives two instances with identical stimulus: one with the default B3/S23
//   rule and 16-bit total, one with the HighLife rule (B36/S23) and a 2-bit
//   saturating total. A queue-based reference model tracks in-flight windows,
//   expected results, latency and handshake readiness.

module tb_neighbour_rule_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       in_valid;
  logic [8:0] in_window;
  logic       out_ready;
  logic       stats_clr;

  logic        in_ready_a, out_valid_a, out_alive_a;
  logic [3:0]  out_count_a;
  logic [15:0] total_a;
  logic        in_ready_b, out_valid_b, out_alive_b;
  logic [3:0]  out_count_b;
  logic [1:0]  total_b;

  localparam logic [8:0] B_DEF = 9'b0_0000_1000;
  localparam logic [8:0] S_DEF = 9'b0_0000_1100;
  localparam logic [8:0] B_HL  = 9'b0_0100_1000;
  localparam logic [8:0] S_HL  = 9'b0_0000_1100;

  neighbour_rule_pipe #(.BIRTH_MASK(B_DEF), .SURVIVE_MASK(S_DEF), .CNT_W(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_a),
    .in_window(in_window), .out_valid(out_valid_a), .out_ready(out_ready),
    .out_alive(out_alive_a), .out_count(out_count_a), .stats_clr(stats_clr),
    .alive_total(total_a)
  );

  neighbour_rule_pipe #(.BIRTH_MASK(B_HL), .SURVIVE_MASK(S_HL), .CNT_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_window(in_window), .out_valid(out_valid_b), .out_ready(out_ready),
    .out_alive(out_alive_b), .out_count(out_count_b), .stats_clr(stats_clr),
    .alive_total(total_b)
  );

  typedef struct {
    logic [8:0] win;
    logic [3:0] cnt;
    logic       alive_a;
    logic       alive_b;
    int         acc;
  } entry_t;

  entry_t q[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int model_tot_a = 0;
  int model_tot_b = 0;

  function automatic int ncount(input logic [8:0] w);
    return $countones(w) - int'(w[4]);
  endfunction

  function automatic logic rule(input logic [8:0] w, input logic [8:0] bm,
                                input logic [8:0] sm);
    int n;
    n = ncount(w);
    return w[4] ? sm[n] : bm[n];
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock cycle: drive inputs at the falling edge, compare the settled
  // outputs with the model, then predict what the next rising edge does.
  task automatic step(input logic v, input logic [8:0] w, input logic ordy,
                      input logic clr, output logic accepted);
    entry_t e;
    logic exp_ready, exp_valid, ofire;
    in_valid = v; in_window = w; out_ready = ordy; stats_clr = clr;
    #1;
    accepted = 1'b0;
    if (!rst_n) begin
      check("rst_in_ready_a", in_ready_a, 0);
      check("rst_in_ready_b", in_ready_b, 0);
      q.delete();
      model_tot_a = 0;
      model_tot_b = 0;
    end else begin
      exp_ready = (q.size() < 2) || ordy;
      check("in_ready_a", in_ready_a, exp_ready);
      check("in_ready_b", in_ready_b, exp_ready);
      exp_valid = (q.size() > 0) && ((cyc - q[0].acc) >= 2);
      check("out_valid_a", out_valid_a, exp_valid);
      check("out_valid_b", out_valid_b, exp_valid);
      if (exp_valid) begin
        check("out_count_a", out_count_a, q[0].cnt);
        check("out_count_b", out_count_b, q[0].cnt);
        check("out_alive_a", out_alive_a, q[0].alive_a);
        check("out_alive_b", out_alive_b, q[0].alive_b);
      end else begin
        check("idle_count_a", out_count_a, 0);
        check("idle_alive_a", out_alive_a, 0);
        check("idle_count_b", out_count_b, 0);
        check("idle_alive_b", out_alive_b, 0);
      end
      check("total_a", total_a, model_tot_a);
      check("total_b", total_b, model_tot_b);
      ofire = exp_valid && ordy;
      e = '{win: 9'd0, cnt: 4'd0, alive_a: 1'b0, alive_b: 1'b0, acc: 0};
      if (ofire) begin
        e = q.pop_front();
        $display("out  cyc %0d win %b count %0d alive_a %0d alive_b %0d",
                 cyc, e.win, e.cnt, e.alive_a, e.alive_b);
      end
      if (clr) begin
        model_tot_a = 0;
        model_tot_b = 0;
      end else if (ofire) begin
        if (e.alive_a && model_tot_a < 65535) model_tot_a++;
        if (e.alive_b && model_tot_b < 3) model_tot_b++;
      end
      if (v && exp_ready) begin
        e.win = w;
        e.cnt = 4'(ncount(w));
        e.alive_a = rule(w, B_DEF, S_DEF);
        e.alive_b = rule(w, B_HL, S_HL);
        e.acc = cyc;
        q.push_back(e);
        accepted = 1'b1;
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  logic acc;
  logic [8:0] wins [10];
  logic [8:0] dir_wins [4];
  int idx;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_window = '0; out_ready = 1'b0; stats_clr = 1'b0;

    // Reset, then the first cycle after release checks reset state.
    repeat (3) step(1'b1, 9'h1FF, 1'b1, 1'b0, acc);
    rst_n = 1'b1;

    // Directed windows: S2 survive, B3 birth, full (dies), HighLife B6.
    dir_wins[0] = 9'b000_010_011;
    dir_wins[1] = 9'b000_000_111;
    dir_wins[2] = 9'b111_111_111;
    dir_wins[3] = 9'b111_101_100;
    for (int i = 0; i < 4; i++) step(1'b1, dir_wins[i], 1'b1, 1'b0, acc);
    repeat (3) step(1'b0, 9'h1FF, 1'b1, 1'b0, acc);

    // Ten-window stream with a five-cycle downstream stall in the middle.
    for (int i = 0; i < 10; i++) wins[i] = 9'($urandom);
    idx = 0;
    for (int c = 0; c < 100 && idx < 10; c++) begin
      step(1'b1, wins[idx], !(c >= 3 && c < 8), 1'b0, acc);
      if (acc) idx++;
    end
    check("stream_sent", idx, 10);
    repeat (4) step(1'b0, 9'h000, 1'b1, 1'b0, acc);

    // Saturation of the 2-bit total, then clear coincident with an alive transfer.
    step(1'b0, 9'h000, 1'b1, 1'b1, acc);
    repeat (5) step(1'b1, 9'b000_000_111, 1'b1, 1'b0, acc);
    repeat (3) step(1'b0, 9'h000, 1'b1, 1'b0, acc);
    step(1'b1, 9'b000_000_111, 1'b1, 1'b0, acc);
    step(1'b0, 9'h000, 1'b1, 1'b0, acc);
    step(1'b0, 9'h000, 1'b1, 1'b1, acc);
    repeat (2) step(1'b0, 9'h000, 1'b1, 1'b0, acc);

    // Fill both stages, reset mid-flight, then a fresh window at latency 2.
    repeat (3) step(1'b1, 9'b000_000_111, 1'b0, 1'b0, acc);
    rst_n = 1'b0;
    step(1'b1, 9'h0FF, 1'b1, 1'b0, acc);
    rst_n = 1'b1;
    step(1'b1, 9'b000_010_011, 1'b1, 1'b0, acc);
    repeat (3) step(1'b0, 9'h000, 1'b1, 1'b0, acc);

    // Randomized traffic with back-pressure, clears and occasional resets.
    for (int i = 0; i < 600; i++) begin
      rst_n = ($urandom_range(0, 99) != 0);
      step($urandom_range(0, 3) != 0, 9'($urandom), $urandom_range(0, 3) != 0,
           $urandom_range(0, 19) == 0, acc);
    end
    rst_n = 1'b1;
    repeat (4) step(1'b0, 9'h000, 1'b1, 1'b0, acc);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
